// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing bus of the branch resolver: prediction push, resolution and training/flush outputs.
interface branch_resolver_if #(
  parameter int unsigned PCW = 32
);
  logic           pred_valid;
  logic           pred_taken;
  logic [PCW-1:0] pred_pc;
  logic [PCW-1:0] pred_target;
  logic           pred_ready;
  logic           res_valid;
  logic           res_taken;
  logic [PCW-1:0] res_target;
  logic           upd_en;
  logic           upd_taken;
  logic           mispredict;
  logic [PCW-1:0] redirect_pc;
  logic           empty;
  logic           err_underflow;

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_en, upd_taken, mispredict, redirect_pc, empty, err_underflow
  );

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_en, upd_taken, mispredict, redirect_pc, empty, err_underflow
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of fetch predictions checked against execute outcomes; trains the predictor and flushes on mispredict.
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PCW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  branch_resolver_if.slave    bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic           taken;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] target;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           pred_ready_q, pred_ready_d;
  logic           empty_q, empty_d;
  logic           upd_en_q, upd_en_d;
  logic           upd_taken_q, upd_taken_d;
  logic           mispredict_q, mispredict_d;
  logic [PCW-1:0] redirect_pc_q, redirect_pc_d;
  logic           err_underflow_q, err_underflow_d;

  entry_t         head_c;
  logic           push_c;
  logic           pop_c;
  logic           mis_c;

  // Push gated by the registered ready so a full queue never accepts, even on a same-cycle pop.
  always_comb begin
    head_c = mem_q[rd_ptr_q];
    push_c = bus.pred_valid && pred_ready_q;
    pop_c  = bus.res_valid && !empty_q;
    mis_c  = pop_c && ((head_c.taken != bus.res_taken) ||
                       (head_c.taken && bus.res_taken && (head_c.target != bus.res_target)));
  end

  always_comb begin
    mem_d           = mem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    upd_en_d        = 1'b0;
    upd_taken_d     = upd_taken_q;
    mispredict_d    = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    err_underflow_d = err_underflow_q;

    if (bus.res_valid && empty_q) begin
      err_underflow_d = 1'b1;
    end

    if (pop_c) begin
      upd_en_d    = 1'b1;
      upd_taken_d = bus.res_taken;
    end

    if (mis_c) begin
      // Everything younger than the mispredicted branch is wrong-path, including a same-cycle push.
      mispredict_d  = 1'b1;
      redirect_pc_d = bus.res_taken ? bus.res_target : (head_c.pc + PCW'(4));
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_d - CW'(1);
      end
      if (push_c) begin
        mem_d[wr_ptr_q] = '{taken: bus.pred_taken, pc: bus.pred_pc, target: bus.pred_target};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        count_d         = count_d + CW'(1);
      end
    end

    pred_ready_d = (count_d != CW'(DEPTH));
    empty_d      = (count_d == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      pred_ready_q    <= 1'b1;
      empty_q         <= 1'b1;
      upd_en_q        <= 1'b0;
      upd_taken_q     <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      pred_ready_q    <= pred_ready_d;
      empty_q         <= empty_d;
      upd_en_q        <= upd_en_d;
      upd_taken_q     <= upd_taken_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign bus.pred_ready    = pred_ready_q;
  assign bus.empty         = empty_q;
  assign bus.upd_en        = upd_en_q;
  assign bus.upd_taken     = upd_taken_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.err_underflow = err_underflow_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Saturating event counters.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (pop_c && (stat_branches_q != '1)) stat_branches_d = stat_branches_q + 32'd1;
    if (mis_c && (stat_mispredicts_q != '1)) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
